// File: rtl/sync_ptr_rx.sv
// Read-domain receiver for the gray-coded RX FIFO write pointer: synchroniser,
// gray-to-binary conversion, fill level, almost-empty flag and sticky integrity checks.
module sync_ptr_rx #(
  parameter int unsigned ADDRSIZE    = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   rptr_bin,
  input  logic                err_clr,
  output logic [ADDRSIZE:0]   rq_wptr,
  output logic [ADDRSIZE:0]   rq_wptr_bin,
  output logic                wptr_upd,
  output logic [ADDRSIZE:0]   rfill,
  output logic                rempty_ae,
  output logic                gray_err,
  output logic                ovf_err
);

  localparam int unsigned PW    = ADDRSIZE + 1;
  localparam int unsigned DEPTH = 32'(1) << ADDRSIZE;

  // Parameter legality is enforced at elaboration
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_ptr_rx: SYNC_STAGES must be in 2..4");
  end
  if (AE_THRESH > DEPTH) begin : g_bad_thresh
    $error("sync_ptr_rx: AE_THRESH must not exceed 2**ADDRSIZE");
  end

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0]                  gprev;
  logic [PW-1:0]                  bin_c;
  logic [PW-1:0]                  gdiff_c;
  logic                           multi_c;
  logic [PW-1:0]                  fill_c;
  logic                           ovf_c;
  logic                           ae_c;

  // Plain flop chain, nothing between stages; index 0 is the first stage
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wptr};
    end
  end

  assign rq_wptr = sync_q[SYNC_STAGES-1];

  // Gray to binary: bin[i] is the xor of all gray bits at and above i
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < int'(PW); i++) begin
      bin_c[i] = ^(rq_wptr >> i);
    end
  end

  // More than one set bit in the sample-to-sample difference is a gray violation
  always_comb begin
    gdiff_c = rq_wptr ^ gprev;
    multi_c = (gdiff_c & (gdiff_c - PW'(1))) != '0;
  end

  // Modulo fill against the local read pointer
  always_comb begin
    fill_c = rq_wptr_bin - rptr_bin;
    ovf_c  = fill_c > PW'(DEPTH);
    ae_c   = fill_c <= PW'(AE_THRESH);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      gprev       <= '0;
      rq_wptr_bin <= '0;
      wptr_upd    <= 1'b0;
      rfill       <= '0;
      rempty_ae   <= 1'b1;
    end else begin
      gprev       <= rq_wptr;
      rq_wptr_bin <= bin_c;
      wptr_upd    <= bin_c != rq_wptr_bin;
      rfill       <= fill_c;
      rempty_ae   <= ae_c;
    end
  end

  // Sticky flags: a coincident set condition beats err_clr
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      gray_err <= 1'b0;
      ovf_err  <= 1'b0;
    end else begin
      gray_err <= multi_c | (gray_err & ~err_clr);
      ovf_err  <= ovf_c   | (ovf_err  & ~err_clr);
    end
  end

endmodule
